// File: rtl/servo_pwm_gen_if.sv
// servo_pwm_gen_if: duty/enable request bus and PWM status outputs of the servo PWM stage
interface servo_pwm_if;
  logic       enable;
  logic [9:0] duty_cycle_input;
  logic       servoSignal;
  logic       period_start;
  logic       duty_clamped;
  modport master (output enable, duty_cycle_input, input servoSignal, period_start, duty_clamped);
  modport slave  (input enable, duty_cycle_input, output servoSignal, period_start, duty_clamped);
endinterface

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: 50 Hz servo PWM with period-boundary double-buffered, clamped duty
module servo_pwm_gen #(
  parameter int TICK_DIV     = 488,
  parameter int DUTY_MIN     = 26,
  parameter int DUTY_MAX     = 128,
  parameter int DUTY_NEUTRAL = 77
) (
  input  logic      clk25mhz,
  input  logic      reset,
  servo_pwm_if.slave bus
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [9:0] D_MIN = 10'(DUTY_MIN);
  localparam logic [9:0] D_MAX = 10'(DUTY_MAX);
  localparam logic [9:0] D_NEU = 10'(DUTY_NEUTRAL);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]    pos_cnt_q, pos_cnt_d, duty_shadow_q, duty_shadow_d;
  logic          servo_q, servo_d, period_start_q, period_start_d, duty_clamped_q, duty_clamped_d;
  logic          tick, wrap, lo, hi;
  always_comb begin
    tick           = div_cnt_q == DIV_LAST;
    wrap           = tick && pos_cnt_q == 10'h3ff;
    lo             = bus.duty_cycle_input < D_MIN;
    hi             = bus.duty_cycle_input > D_MAX;
    div_cnt_d      = tick ? '0 : div_cnt_q + 1'b1;
    pos_cnt_d      = tick ? pos_cnt_q + 10'd1 : pos_cnt_q;
    duty_shadow_d  = wrap ? (lo ? D_MIN : hi ? D_MAX : bus.duty_cycle_input) : duty_shadow_q;
    duty_clamped_d = wrap ? (lo || hi) : duty_clamped_q;
    period_start_d = wrap;
    // compares the pre-edge position, giving the one-cycle output latency
    servo_d        = bus.enable && (pos_cnt_q < duty_shadow_q);
  end
  always_ff @(posedge clk25mhz) begin
    if (!reset) begin
      div_cnt_q      <= '0;
      pos_cnt_q      <= '0;
      duty_shadow_q  <= D_NEU;
      servo_q        <= 1'b0;
      period_start_q <= 1'b0;
      duty_clamped_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pos_cnt_q      <= pos_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      servo_q        <= servo_d;
      period_start_q <= period_start_d;
      duty_clamped_q <= duty_clamped_d;
    end
  end
  assign bus.servoSignal  = servo_q;
  assign bus.period_start = period_start_q;
  assign bus.duty_clamped = duty_clamped_q;
endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: vector table, corner sequences and random run against a cycle-index model
module tb_servo_pwm_gen;
  localparam int TD = 4;
  localparam int PER = 1024 * TD;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int total = 0;
  int bad = 0;
  bit chk_on = 0;
  bit def_done = 0;
  servo_pwm_if bus ();
  servo_pwm_if bus2 ();
  servo_pwm_gen #(.TICK_DIV(TD)) dut (.clk25mhz(clk), .reset(rst_n), .bus(bus));
  servo_pwm_gen u_def (.clk25mhz(clk), .reset(rst2_n), .bus(bus2));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: output of each edge derived from its index within the run since reset
  int n;
  int shadow;
  bit e_sig, e_ps, e_cl;
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; shadow = 77; e_sig = 0; e_ps = 0; e_cl = 0;
    end else begin
      e_sig = bus.enable && ((n % PER) / TD < shadow);
      e_ps  = (n % PER) == PER - 1;
      if (e_ps) begin
        e_cl   = bus.duty_cycle_input < 26 || bus.duty_cycle_input > 128;
        shadow = bus.duty_cycle_input < 26 ? 26 : bus.duty_cycle_input > 128 ? 128 : int'(bus.duty_cycle_input);
      end
      n++;
    end
  end
  always @(negedge clk)
    if (chk_on)
      chk("cycle_model", {bus.servoSignal, bus.period_start, bus.duty_clamped}, {e_sig, e_ps, e_cl});

  task automatic wait_ps(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.period_start && k < PER + 8);
    if (!bus.period_start) chk("ps_timeout", 0, 1);
  endtask

  task automatic run_period(input int chg_at, input int chg_duty, output int hi, output int len, output int first);
    hi = 0; len = 0; first = 0;
    do begin
      if (len == chg_at) bus.duty_cycle_input = 10'(chg_duty);
      @(negedge clk);
      len++;
      if (bus.servoSignal && first == 0) first = len;
      hi += int'(bus.servoSignal);
    end while (!bus.period_start && len < PER + 8);
  endtask

  typedef struct { int duty; int hi; bit cl; } vec_t;
  vec_t tbl[7];

  initial begin
    int hi, len, first, k;
    tbl[0] = '{77, 308, 0};
    tbl[1] = '{0, 104, 1};
    tbl[2] = '{1023, 512, 1};
    tbl[3] = '{51, 204, 0};
    tbl[4] = '{25, 104, 1};
    tbl[5] = '{128, 512, 0};
    tbl[6] = '{77, 308, 0};
    bus.enable = 1'b1;
    bus.duty_cycle_input = 10'd77;
    repeat (3) @(negedge clk);
    chk("rst_sig", int'(bus.servoSignal), 0);
    chk("rst_ps", int'(bus.period_start), 0);
    chk("rst_cl", int'(bus.duty_clamped), 0);
    chk_on = 1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_rise", int'(bus.servoSignal), 1);
    wait_ps(k);
    chk("first_period", k + 1, PER);
    run_period(0, tbl[0].duty, hi, len, first);
    for (int i = 0; i < 7; i++) begin
      chk("tbl_clamped", int'(bus.duty_clamped), int'(tbl[i].cl));
      run_period(0, tbl[i < 6 ? i + 1 : i].duty, hi, len, first);
      chk("tbl_high", hi, tbl[i].hi);
      chk("tbl_len", len, PER);
      chk("tbl_rise_ofs", first, 1);
    end
    run_period(100, 92, hi, len, first);
    chk("midchg_cur", hi, 308);
    chk("midchg_cl", int'(bus.duty_clamped), 0);
    run_period(0, 92, hi, len, first);
    chk("midchg_next", hi, 368);
    repeat (50) @(negedge clk);
    chk("en_pulse", int'(bus.servoSignal), 1);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_drop", int'(bus.servoSignal), 0);
    repeat (100) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("en_resume", int'(bus.servoSignal), 1);
    wait_ps(k);
    chk("en_spacing", 152 + k, PER);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_sig", int'(bus.servoSignal), 0);
    chk("mid_rst_ps", int'(bus.period_start), 0);
    chk("mid_rst_cl", int'(bus.duty_clamped), 0);
    rst_n = 1'b1;
    run_period(-1, 0, hi, len, first);
    chk("post_rst_high", hi, 308);
    chk("post_rst_len", len, PER);
    for (int c = 0; c < 3 * PER; c++) begin
      if ($urandom_range(63) == 0) bus.duty_cycle_input = 10'($urandom_range(1023));
      if ($urandom_range(63) == 1) bus.duty_cycle_input = 10'($urandom_range(130, 24));
      if ($urandom_range(199) == 0) bus.enable = ~bus.enable;
      rst_n = $urandom_range(5999) != 0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    k = 0;
    while (!def_done && k < 50000) begin @(negedge clk); k++; end
    chk("def_done", int'(def_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int hi, k;
    bit seen;
    hi = 0; k = 0; seen = 0;
    bus2.enable = 1'b1;
    bus2.duty_cycle_input = 10'd77;
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    while (k < 40000 && !(seen && !bus2.servoSignal)) begin
      @(negedge clk);
      k++;
      if (bus2.servoSignal) begin seen = 1; hi++; end
      if (bus2.period_start) chk("def_no_ps", 1, 0);
    end
    chk("def_high", hi, 37576);
    def_done = 1;
  end
endmodule
